// File: rtl/color_detector_pipe_pkg.sv
// +--------------------------------------------------------------------------+
// | color_detector_pipe_pkg : shared constants and cfg_data field layout     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package color_detector_pipe_pkg;

  localparam int MAX_COLORS = 8;
  localparam int IDX_W = $clog2(MAX_COLORS);
  localparam logic [1:0] MARK_PREFIX = 2'b01;

  // Field slots inside cfg_data, counted in DATA_W units from the LSB.
  typedef enum logic [2:0] {
    FLD_CR_HI = 3'd0,
    FLD_CR_LO = 3'd1,
    FLD_CB_HI = 3'd2,
    FLD_CB_LO = 3'd3,
    FLD_Y_MIN = 3'd4,
    FLD_EN    = 3'd5
  } cfg_field_e;

  function automatic int cfg_w(input int dw);
    return 5 * dw + 1;
  endfunction

  function automatic int fld_lsb(input int dw, input cfg_field_e f);
    return int'(f) * dw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/color_detector_pipe_if.sv
// +--------------------------------------------------------------------------+
// | color_detector_pipe_if : pixel, config and frame-count bundle            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface color_detector_pipe_if
  import color_detector_pipe_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int N_COLORS = 4,
  parameter int CNT_W    = 19
);
  logic                      e_pix;
  logic [DATA_W-1:0]         Y;
  logic [DATA_W-1:0]         Cb;
  logic [DATA_W-1:0]         Cr;
  logic                      vsync;
  logic                      cfg_we;
  logic [IDX_W-1:0]          cfg_idx;
  logic [5*DATA_W:0]         cfg_data;

  logic                      pix_valid;
  logic [DATA_W-1:0]         y_out;
  logic                      hit;
  logic [IDX_W-1:0]          match_id;
  logic [N_COLORS-1:0]       match_mask;
  logic [N_COLORS*CNT_W-1:0] frame_count;
  logic                      count_valid;

  modport master (
    output e_pix, Y, Cb, Cr, vsync, cfg_we, cfg_idx, cfg_data,
    input  pix_valid, y_out, hit, match_id, match_mask, frame_count, count_valid
  );

  modport slave (
    input  e_pix, Y, Cb, Cr, vsync, cfg_we, cfg_idx, cfg_data,
    output pix_valid, y_out, hit, match_id, match_mask, frame_count, count_valid
  );
endinterface

`default_nettype wire

// File: rtl/color_window_cmp.sv
// +--------------------------------------------------------------------------+
// | color_window_cmp : combinational test of one pixel against one window    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module color_window_cmp #(
  parameter int DATA_W = 8
) (
  input  logic              en,
  input  logic [DATA_W-1:0] y_min,
  input  logic [DATA_W-1:0] cb_lo,
  input  logic [DATA_W-1:0] cb_hi,
  input  logic [DATA_W-1:0] cr_lo,
  input  logic [DATA_W-1:0] cr_hi,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] cb,
  input  logic [DATA_W-1:0] cr,
  output logic              match
);
  // Inclusive unsigned bounds; an inverted range (lo > hi) can never be satisfied.
  assign match = en
               & (y  >= y_min)
               & (cb >= cb_lo) & (cb <= cb_hi)
               & (cr >= cr_lo) & (cr <= cr_hi);
endmodule

`default_nettype wire

// File: rtl/color_detector_pipe.sv
// +--------------------------------------------------------------------------+
// | color_detector_pipe : N-window YCbCr classifier with per-frame counts    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module color_detector_pipe
  import color_detector_pipe_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_COLORS  = 4,
  parameter int CNT_W     = 19,
  parameter int MARK_MODE = 1
) (
  input logic                 PCLK,
  input logic                 rst_n,
  color_detector_pipe_if.slave bus
);
  localparam int CFG_W  = cfg_w(DATA_W);
  localparam int EN_BIT = fld_lsb(DATA_W, FLD_EN);
  localparam int YM_LSB = fld_lsb(DATA_W, FLD_Y_MIN);
  localparam int BL_LSB = fld_lsb(DATA_W, FLD_CB_LO);
  localparam int BH_LSB = fld_lsb(DATA_W, FLD_CB_HI);
  localparam int RL_LSB = fld_lsb(DATA_W, FLD_CR_LO);
  localparam int RH_LSB = fld_lsb(DATA_W, FLD_CR_HI);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CFG_W-1:0]  shadow [N_COLORS];
  logic [CFG_W-1:0]  active [N_COLORS];
  logic              vsync_d;
  logic              armed;
  logic              frame_edge;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_y;
  logic [DATA_W-1:0] s1_cb;
  logic [DATA_W-1:0] s1_cr;
  logic [N_COLORS-1:0] win_match;
  logic [IDX_W-1:0]  prio_id;
  logic [DATA_W-1:0] y_mark;
  logic [CNT_W-1:0]  cnt [N_COLORS];

  assign frame_edge = bus.vsync & ~vsync_d;

  // Shadow takes writes any time; active only refreshes on a frame edge, so a
  // write landing on the edge cycle reaches active one frame later.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_COLORS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_COLORS; i++) begin
        if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i)))
          shadow[i] <= bus.cfg_data;
        if (frame_edge)
          active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
      s1_cb    <= '0;
      s1_cr    <= '0;
    end else begin
      s1_valid <= bus.e_pix;
      if (bus.e_pix) begin
        s1_y  <= bus.Y;
        s1_cb <= bus.Cb;
        s1_cr <= bus.Cr;
      end
    end
  end

  for (genvar i = 0; i < N_COLORS; i++) begin : g_win
    color_window_cmp #(.DATA_W(DATA_W)) u_cmp (
      .en    (active[i][EN_BIT]),
      .y_min (active[i][YM_LSB +: DATA_W]),
      .cb_lo (active[i][BL_LSB +: DATA_W]),
      .cb_hi (active[i][BH_LSB +: DATA_W]),
      .cr_lo (active[i][RL_LSB +: DATA_W]),
      .cr_hi (active[i][RH_LSB +: DATA_W]),
      .y     (s1_y),
      .cb    (s1_cb),
      .cr    (s1_cr),
      .match (win_match[i])
    );
  end

  always_comb begin
    prio_id = '0;
    for (int i = N_COLORS - 1; i >= 0; i--)
      if (win_match[i]) prio_id = IDX_W'(i);
  end

  assign y_mark = ((MARK_MODE != 0) && (|win_match)) ? {MARK_PREFIX, s1_y[DATA_W-1:2]} : s1_y;

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      bus.pix_valid  <= 1'b0;
      bus.y_out      <= '0;
      bus.hit        <= 1'b0;
      bus.match_id   <= '0;
      bus.match_mask <= '0;
    end else begin
      bus.pix_valid <= s1_valid;
      if (s1_valid) begin
        bus.y_out      <= y_mark;
        bus.hit        <= |win_match;
        bus.match_id   <= prio_id;
        bus.match_mask <= win_match;
      end else begin
        bus.hit      <= 1'b0;
        bus.match_id <= '0;
      end
    end
  end

  // Counters run off the registered S2 result; a hit on the edge cycle seeds the new frame.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d         <= 1'b0;
      armed           <= 1'b0;
      bus.count_valid <= 1'b0;
      bus.frame_count <= '0;
      for (int i = 0; i < N_COLORS; i++) cnt[i] <= '0;
    end else begin
      vsync_d         <= bus.vsync;
      bus.count_valid <= frame_edge & armed;
      if (frame_edge) begin
        armed <= 1'b1;
        if (armed)
          for (int i = 0; i < N_COLORS; i++) bus.frame_count[i*CNT_W +: CNT_W] <= cnt[i];
      end
      for (int i = 0; i < N_COLORS; i++) begin
        if (frame_edge)
          cnt[i] <= (bus.pix_valid && bus.match_mask[i]) ? CNT_W'(1) : '0;
        else if (bus.pix_valid && bus.match_mask[i] && (cnt[i] != CNT_MAX))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
